// File: rtl/vga_pixel_feeder_if.sv
// Pixel stream handshake into the VGA pixel feeder.
// The source drives data/valid, and the feeder drives ready.
`timescale 1ns/1ps
interface vga_pixel_feeder_if;
  logic [23:0] In_Data;
  logic        In_Valid;
  logic        In_Ready;

  modport master (
    output In_Data,
    output In_Valid,
    input  In_Ready
  );

  modport slave (
    input  In_Data,
    input  In_Valid,
    output In_Ready
  );
endinterface

// File: rtl/vga_pixel_feeder.sv
// Show-ahead pixel FIFO feeding the VGA timing controller, resynced on VS fall.
// Optional underflow pixel counter: define PIX_FEEDER_UFLOW_CNT_EN.
`timescale 1ns/1ps
module vga_pixel_feeder #(
  parameter int          DEPTH      = 512,
  parameter int          AW         = 9,
  parameter int          PREFILL    = 256,
  parameter logic [23:0] FILL_COLOR = 24'h000000
) (
  input  logic               Clk,
  input  logic               Reset_n,
  vga_pixel_feeder_if.slave  in_if,
  output logic               Frame_Req,
  input  logic               VGA_VS,
  input  logic               Data_Req,
  output logic [23:0]        DATA,
  output logic [AW:0]        Fifo_Level,
  output logic               Underflow,
  output logic [15:0]        Uflow_Cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FLUSH,
    S_PREFILL,
    S_RUN
  } state_t;

  localparam logic [AW:0] PREFILL_LVL = (AW+1)'(PREFILL);
  localparam logic [AW:0] ONE         = (AW+1)'(1);

  state_t      state_q, state_d;
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0] level_q, level_d;
  logic        full_q, full_d;
  logic        uflow_q, uflow_d;
  logic        vs_q;
  logic [23:0] mem_q [DEPTH];

  logic empty;
  logic run;
  logic vs_fall;
  logic push;
  logic pop;
  logic uf_evt;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign run     = (state_q == S_RUN);
  assign vs_fall = vs_q & ~VGA_VS;

  assign in_if.In_Ready = ~full_q &
                          ((state_q == S_PREFILL) | run);

  assign push   = in_if.In_Valid & in_if.In_Ready;
  assign pop    = Data_Req & ~empty & run;
  assign uf_evt = Data_Req & (empty | ~run);

  assign DATA = (run & ~empty) ?
                mem_q[rd_ptr_q[AW-1:0]] : FILL_COLOR;

  assign Frame_Req  = (state_q == S_FLUSH);
  assign Fifo_Level = level_q;
  assign Underflow  = uflow_q;

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = push ? wr_ptr_q + ONE : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + ONE : rd_ptr_q;
    level_d  = level_q;
    if (push & ~pop) level_d = level_q + ONE;
    if (pop & ~push) level_d = level_q - ONE;
    uflow_d  = uflow_q | uf_evt;
    unique case (state_q)
      S_IDLE: begin
        if (vs_fall) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        level_d  = '0;
        uflow_d  = 1'b0;
        state_d  = S_PREFILL;
      end
      S_PREFILL: begin
        if (vs_fall)
          state_d = S_FLUSH;
        else if (level_q >= PREFILL_LVL)
          state_d = S_RUN;
      end
      S_RUN: begin
        if (vs_fall) state_d = S_FLUSH;
      end
      default: state_d = S_IDLE;
    endcase
    full_d = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
             (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      uflow_q  <= 1'b0;
      vs_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      uflow_q  <= uflow_d;
      vs_q     <= VGA_VS;
    end
  end

  // Storage has no reset; only slots between the pointers are ever read.
  always_ff @(posedge Clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= in_if.In_Data;
  end

`ifdef PIX_FEEDER_UFLOW_CNT_EN
  logic [15:0] ucnt_q, ucnt_d;

  always_comb begin
    ucnt_d = ucnt_q;
    if (uf_evt && (ucnt_q != 16'hFFFF))
      ucnt_d = ucnt_q + 16'd1;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) ucnt_q <= '0;
    else          ucnt_q <= ucnt_d;
  end

  assign Uflow_Cnt = ucnt_q;
`else
  assign Uflow_Cnt = '0;
`endif

endmodule

// File: tb/tb_vga_pixel_feeder.sv
// Scoreboard bench for vga_pixel_feeder against a queue-based pixel model.
// Honours PIX_FEEDER_UFLOW_CNT_EN the same way as the design.
`timescale 1ns/1ps
module tb_vga_pixel_feeder;

  localparam int          DEPTH   = 512;
  localparam int          AW      = 9;
  localparam int          PREFILL = 256;
  localparam logic [23:0] FILL    = 24'h000000;

  logic          Clk = 1'b0;
  logic          Reset_n;
  logic          VGA_VS;
  logic          Data_Req;
  logic          Frame_Req;
  logic [23:0]   DATA;
  logic [AW:0]   Fifo_Level;
  logic          Underflow;
  logic [15:0]   Uflow_Cnt;

  vga_pixel_feeder_if pif ();

  vga_pixel_feeder #(
    .DEPTH      (DEPTH),
    .AW         (AW),
    .PREFILL    (PREFILL),
    .FILL_COLOR (FILL)
  ) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .in_if      (pif.slave),
    .Frame_Req  (Frame_Req),
    .VGA_VS     (VGA_VS),
    .Data_Req   (Data_Req),
    .DATA       (DATA),
    .Fifo_Level (Fifo_Level),
    .Underflow  (Underflow),
    .Uflow_Cnt  (Uflow_Cnt)
  );

  always #5 Clk = ~Clk;

  typedef enum {M_WAIT, M_RESTART, M_FILL, M_PLAY} mode_t;

  typedef struct {
    bit rdy;
    bit freq;
    int lvl;
    bit uf;
    int uc;
  } st_t;

  // Reference model state
  logic [23:0] q[$];
  mode_t       mode;
  bit          vs_prev;
  bit          uflag;
  int          ucnt;

  st_t         sq[$];
  logic [23:0] dq[$];
  bit          mon_en = 1'b0;
  int          n_chk  = 0;
  int          n_pass = 0;
  bit          acc;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h @%0t",
                  nm, act, exp, $time);
  endtask

  task automatic model_reset();
    q.delete();
    sq.delete();
    dq.delete();
    mode    = M_WAIT;
    vs_prev = 1'b1;
    uflag   = 1'b0;
    ucnt    = 0;
  endtask

  // Called at posedge+1: drives one cycle, queues expectations, steps model.
  task automatic cycle(input bit v, input logic [23:0] d,
                       input bit r, input bit vs,
                       output bit a);
    st_t s;
    bit  rdy, serve, under, fall;
    pif.In_Valid = v;
    pif.In_Data  = d;
    Data_Req     = r;
    VGA_VS       = vs;
    rdy   = (mode == M_FILL || mode == M_PLAY) && q.size() < DEPTH;
    serve = r && mode == M_PLAY && q.size() != 0;
    under = r && !serve;
    s.rdy  = rdy;
    s.freq = (mode == M_RESTART);
    s.lvl  = q.size();
    s.uf   = uflag;
    s.uc   = ucnt;
    sq.push_back(s);
    if (r) dq.push_back(serve ? q[0] : FILL);
    a    = v && rdy;
    fall = vs_prev && !vs;
    @(posedge Clk);
    if (serve) void'(q.pop_front());
    if (a) q.push_back(d);
    if (mode == M_RESTART) uflag = 1'b0;
    else if (under) uflag = 1'b1;
`ifdef PIX_FEEDER_UFLOW_CNT_EN
    if (under && ucnt < 65535) ucnt++;
`endif
    case (mode)
      M_WAIT:    if (fall) mode = M_RESTART;
      M_RESTART: begin q.delete(); mode = M_FILL; end
      M_FILL: begin
        if (fall) mode = M_RESTART;
        else if (s.lvl >= PREFILL) mode = M_PLAY;
      end
      M_PLAY:    if (fall) mode = M_RESTART;
      default:   mode = M_WAIT;
    endcase
    vs_prev = vs;
    #1;
  endtask

  function automatic logic [23:0] rnd24();
    return 24'($urandom);
  endfunction

  always @(negedge Clk) begin : monitor
    st_t s;
    if (mon_en) begin
      if (sq.size() != 0) begin
        s = sq.pop_front();
        chk("in_ready", 32'(pif.In_Ready), 32'(s.rdy));
        chk("frame_req", 32'(Frame_Req), 32'(s.freq));
        chk("fifo_level", 32'(Fifo_Level), 32'(s.lvl));
        chk("underflow", 32'(Underflow), 32'(s.uf));
        chk("uflow_cnt", 32'(Uflow_Cnt), 32'(s.uc));
      end
      if (Data_Req) begin
        if (dq.size() == 0) begin
          n_chk++;
          $display("FAIL data: request with no expected pixel @%0t",
                   $time);
        end else begin
          chk("data", 32'(DATA), 32'(dq.pop_front()));
        end
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 32'(pif.In_Ready), 32'd0);
    chk({tag, "_frame_req"}, 32'(Frame_Req), 32'd0);
    chk({tag, "_level"}, 32'(Fifo_Level), 32'd0);
    chk({tag, "_underflow"}, 32'(Underflow), 32'd0);
    chk({tag, "_uflow_cnt"}, 32'(Uflow_Cnt), 32'd0);
    chk({tag, "_data"}, 32'(DATA), 32'(FILL));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int idx;
    int guard;
    Reset_n      = 1'b0;
    VGA_VS       = 1'b1;
    Data_Req     = 1'b0;
    pif.In_Valid = 1'b0;
    pif.In_Data  = '0;
    model_reset();
    repeat (5) @(posedge Clk);
    #1;
    chk_reset_outputs("rst");
    Reset_n = 1'b1;
    mon_en  = 1'b1;

    // Idle until the first VS fall: nothing accepted, fill colour served
    for (int i = 0; i < 12; i++)
      cycle($urandom_range(0, 1) != 0, rnd24(),
            $urandom_range(0, 1) != 0, 1'b1, acc);

    // Frame start and prefill with 1..256
    cycle(1'b1, 24'd1, 1'b0, 1'b0, acc);
    idx   = 1;
    guard = 0;
    while (idx <= PREFILL && guard < 400) begin
      cycle(1'b1, 24'(idx), 1'b0, 1'b1, acc);
      if (acc) idx++;
      guard++;
    end
    cycle(1'b0, 24'd0, 1'b0, 1'b1, acc);
    for (int i = 0; i < 4; i++)
      cycle(1'b0, 24'd0, 1'b1, 1'b1, acc);

    // Fill to full, hold, then a single request reopens ready
    for (int i = 0; i < 300; i++)
      cycle(1'b1, rnd24(), 1'b0, 1'b1, acc);
    cycle(1'b1, rnd24(), 1'b1, 1'b1, acc);
    for (int i = 0; i < 3; i++)
      cycle(1'b1, rnd24(), 1'b0, 1'b1, acc);

    // Drain to level 2, then run dry
    guard = 0;
    while (q.size() > 2 && guard < 700) begin
      cycle(1'b0, 24'd0, 1'b1, 1'b1, acc);
      guard++;
    end
    for (int i = 0; i < 4; i++)
      cycle(1'b0, 24'd0, 1'b1, 1'b1, acc);
    // Push coinciding with a request at empty
    cycle(1'b1, 24'hABCDEF, 1'b1, 1'b1, acc);
    cycle(1'b0, 24'd0, 1'b1, 1'b1, acc);

    // Mid-frame resync at level 100
    guard = 0;
    while (q.size() < 100 && guard < 300) begin
      cycle(1'b1, rnd24(), 1'b0, 1'b1, acc);
      guard++;
    end
    cycle(1'b1, rnd24(), 1'b1, 1'b0, acc);
    for (int i = 0; i < 4; i++)
      cycle(1'b1, rnd24(), 1'b1, 1'b1, acc);

    // Randomised frames with periodic VS pulses
    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(0, 3) != 0, rnd24(),
            $urandom_range(0, 1) != 0,
            !((i % 700) < 3), acc);

    // Reach RUN at level 50 for the async reset check
    cycle(1'b0, 24'd0, 1'b0, 1'b0, acc);
    guard = 0;
    while (mode != M_PLAY && guard < 600) begin
      cycle(1'b1, rnd24(), 1'b0, 1'b1, acc);
      guard++;
    end
    guard = 0;
    while (q.size() > 50 && guard < 600) begin
      cycle(1'b0, 24'd0, 1'b1, 1'b1, acc);
      guard++;
    end
    chk("pre_reset_level", 32'(Fifo_Level), 32'd50);
    cycle(1'b0, 24'd0, 1'b0, 1'b1, acc);
    @(negedge Clk);
    #2;
    Reset_n = 1'b0;
    mon_en  = 1'b0;
    #1;
    chk_reset_outputs("async");
    pif.In_Valid = 1'b0;
    Data_Req     = 1'b0;
    model_reset();
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    mon_en  = 1'b1;

    for (int i = 0; i < 10; i++)
      cycle(1'b1, rnd24(), $urandom_range(0, 1) != 0, 1'b1, acc);
    cycle(1'b1, rnd24(), 1'b0, 1'b0, acc);
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 3) != 0, rnd24(),
            $urandom_range(0, 2) == 0, 1'b1, acc);

    @(negedge Clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
